// File: rtl/io_intr_ctl.sv
// io_intr_ctl: NCH-channel I/O controller with per-channel input FIFOs, output registers
// and a prioritised, vectored interrupt request/acknowledge handshake.
module io_intr_ctl #(
    parameter int NCH    = 4,
    parameter int DW     = 8,
    parameter int FDEPTH = 4,
    parameter int SW     = 2
) (
    input  logic                clk,
    input  logic                com_rst_n,
    input  logic                en,
    input  logic [NCH-1:0]      fgi_bsy,
    input  logic [NCH*DW-1:0]   inpr_in,
    input  logic [NCH-1:0]      fgo_bsy,
    output logic [NCH*DW-1:0]   outr,
    input  logic [SW-1:0]       sel,
    input  logic                inp,
    output logic [DW-1:0]       inp_data,
    input  logic                out_ld,
    input  logic [DW-1:0]       out_data,
    output logic [NCH-1:0]      fgi,
    output logic [NCH-1:0]      fgo,
    output logic [NCH-1:0]      ovf,
    input  logic                ovf_clr,
    input  logic                imsk_ld,
    input  logic [2*NCH-1:0]    imsk_in,
    output logic [2*NCH-1:0]    imsk,
    input  logic                ien_set,
    input  logic                ien_clr,
    output logic                ien,
    output logic                intr_req,
    output logic [SW:0]         intr_vec,
    input  logic                intr_ack
);
    localparam int AW = $clog2(FDEPTH);
    typedef enum logic {IDLE, REQ} state_t;

    state_t                state_q;
    logic [NCH-1:0]        bsy_i_q, bsy_o_q, ovf_q, fgo_q;
    logic [NCH*DW-1:0]     outr_q;
    logic [2*NCH-1:0]      imsk_q, pend;
    logic                  ien_q, req_q, sel_ok;
    logic [SW:0]           vec_q, win;
    logic [AW-1:0]         wp_q [NCH];
    logic [AW-1:0]         rp_q [NCH];
    logic [AW:0]           cnt_q [NCH];
    logic [DW-1:0]         mem_q [NCH][FDEPTH];
    logic [NCH-1:0]        sel_k, rise_i, rise_o, full, pop, push_ok, ovf_set;

    assign sel_ok   = int'(sel) < NCH;
    assign rise_i   = fgi_bsy & ~bsy_i_q;
    assign rise_o   = fgo_bsy & ~bsy_o_q;
    assign outr     = outr_q;
    assign fgo      = fgo_q;
    assign ovf      = ovf_q;
    assign imsk     = imsk_q;
    assign ien      = ien_q;
    assign intr_req = req_q;
    assign intr_vec = vec_q;

    // A full FIFO still accepts a push when the same cycle pops it.
    always_comb begin
        inp_data = '0;
        win      = '0;
        for (int k = 0; k < NCH; k++) begin
            fgi[k]        = cnt_q[k] != '0;
            sel_k[k]      = sel_ok && sel == SW'(k);
            full[k]       = cnt_q[k] == (AW+1)'(FDEPTH);
            pop[k]        = en && inp && sel_k[k] && fgi[k];
            push_ok[k]    = en && rise_i[k] && (!full[k] || pop[k]);
            ovf_set[k]    = en && rise_i[k] && full[k] && !pop[k];
            pend[2*k]     = fgi[k] & imsk_q[2*k];
            pend[2*k+1]   = fgo_q[k] & imsk_q[2*k+1];
            if (sel_k[k] && fgi[k]) inp_data = mem_q[k][rp_q[k]];
        end
        for (int i = 2*NCH-1; i >= 0; i--)
            if (pend[i]) win = (SW+1)'(i);
    end

    always_ff @(posedge clk)
        for (int k = 0; k < NCH; k++)
            if (push_ok[k]) mem_q[k][wp_q[k]] <= inpr_in[k*DW +: DW];

    always_ff @(posedge clk or negedge com_rst_n) begin
        if (!com_rst_n) begin
            bsy_i_q <= '0;
            bsy_o_q <= '0;
            ovf_q   <= '0;
            fgo_q   <= '1;
            outr_q  <= '0;
            imsk_q  <= '0;
            ien_q   <= 1'b0;
            req_q   <= 1'b0;
            vec_q   <= '0;
            state_q <= IDLE;
            for (int k = 0; k < NCH; k++) begin
                wp_q[k]  <= '0;
                rp_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else if (en) begin
            bsy_i_q <= fgi_bsy;
            bsy_o_q <= fgo_bsy;
            imsk_q  <= imsk_ld ? imsk_in : imsk_q;
            ien_q   <= ien_set | (ien_q & ~ien_clr & ~intr_ack);
            for (int k = 0; k < NCH; k++) begin
                wp_q[k]  <= push_ok[k] ? wp_q[k] + AW'(1) : wp_q[k];
                rp_q[k]  <= pop[k] ? rp_q[k] + AW'(1) : rp_q[k];
                cnt_q[k] <= cnt_q[k] + (AW+1)'(push_ok[k]) - (AW+1)'(pop[k]);
                ovf_q[k] <= ovf_set[k] | (ovf_q[k] & ~(ovf_clr & sel_k[k]));
                fgo_q[k] <= rise_o[k] | (fgo_q[k] & ~(out_ld & sel_k[k]));
                if (out_ld && sel_k[k]) outr_q[k*DW +: DW] <= out_data;
            end
            if (state_q == IDLE) begin
                if (ien_q && |pend) begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    vec_q   <= win;
                end
            end else if (intr_ack || (ien_clr && !ien_set)) begin
                state_q <= IDLE;
                req_q   <= 1'b0;
            end
        end
    end
endmodule
